// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bus between the pipeline datapath and the stall/flush controller.
// master: datapath side, drives ID/EX hazard info and receives the register controls.
// slave : controller side, the reverse.
//   id_rs/id_rt/id_uses_*  ID-stage source operands
//   ex_rd/ex_mem_read      EX-stage destination and load flag
//   ex_branch_taken        EX resolved a taken branch/jump
//   ex_mc_start/latency    EX starts a multi-cycle op of the given total length
//   *_we/*_flush           pipeline register write enables and bubble loads
//   mc_busy, stall_count   status and perf counter
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned LAT_W  = 4,
  parameter int unsigned CNT_W  = 16
);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_mem_read;
  logic              ex_branch_taken;
  logic              ex_mc_start;
  logic [LAT_W-1:0]  ex_mc_latency;
  logic              pc_we;
  logic              ifid_we;
  logic              ifid_flush;
  logic              idex_we;
  logic              idex_flush;
  logic              exmem_we;
  logic              exmem_flush;
  logic              mc_busy;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rd, ex_mem_read,
           ex_branch_taken, ex_mc_start, ex_mc_latency,
    input  pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
           exmem_we, exmem_flush, mc_busy, stall_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rd, ex_mem_read,
           ex_branch_taken, ex_mc_start, ex_mc_latency,
    output pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
           exmem_we, exmem_flush, mc_busy, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: load-use bubble,
// taken-branch squash, front-end freeze during multi-cycle EX ops, and a
// saturating stall-cycle counter.
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   hz       hazard-control bus (slave side), see pipeline_hazard_ctrl_if
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned LAT_W  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  pipeline_hazard_ctrl_if.slave  hz
);

  typedef enum logic {RUN, MC_BUSY} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [LAT_W-1:0]  mc_cnt;
  logic [LAT_W-1:0]  mc_cnt_nxt;
  logic [CNT_W-1:0]  stall_cnt;
  logic              lu_c;

  logic pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, exmem_flush, mc_busy;

  // Load-use hazard: EX load feeds a register the ID instruction reads (r0 never hazards)
  always_comb begin
    lu_c = hz.ex_mem_read && (hz.ex_rd != REG_AW'(0)) &&
           ((hz.id_uses_rs && (hz.id_rs == hz.ex_rd)) ||
            (hz.id_uses_rt && (hz.id_rt == hz.ex_rd)));
  end

  // Next-state and control outputs; reset forces every register to load a bubble
  always_comb begin
    state_nxt   = state;
    mc_cnt_nxt  = mc_cnt;
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_we     = 1'b1;
    idex_flush  = 1'b0;
    exmem_we    = 1'b1;
    exmem_flush = 1'b0;
    mc_busy     = 1'b0;
    if (!reset_n) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_we     = 1'b0;
      exmem_we    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (hz.ex_branch_taken) begin
            // Wrong-path IF and ID instructions are squashed; any mc start is dropped
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (hz.ex_mc_start && (hz.ex_mc_latency >= LAT_W'(2))) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_flush = 1'b1;
            mc_cnt_nxt  = hz.ex_mc_latency - LAT_W'(2);
            state_nxt   = MC_BUSY;
          end else if (lu_c) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
          end
        end
        MC_BUSY: begin
          // Front end frozen; EX/MEM receives bubbles until the op completes
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_we     = 1'b0;
          exmem_flush = 1'b1;
          mc_busy     = 1'b1;
          if (mc_cnt == LAT_W'(0)) state_nxt  = RUN;
          else                     mc_cnt_nxt = mc_cnt - LAT_W'(1);
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // State, remaining-cycle counter and saturating stall counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= RUN;
      mc_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      state  <= state_nxt;
      mc_cnt <= mc_cnt_nxt;
      if (!pc_we && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign hz.pc_we       = pc_we;
  assign hz.ifid_we     = ifid_we;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_we     = idex_we;
  assign hz.idex_flush  = idex_flush;
  assign hz.exmem_we    = exmem_we;
  assign hz.exmem_flush = exmem_flush;
  assign hz.mc_busy     = mc_busy;
  assign hz.stall_count = stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed by
// randomized traffic, compared against a remaining-freeze-cycles reference model.
module tb_pipeline_hazard_ctrl;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned LAT_W  = 4;
  localparam int unsigned CNT_W  = 16;
  localparam int          CNT_MAX = 65535;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_AW(REG_AW), .LAT_W(LAT_W), .CNT_W(CNT_W)) hz ();

  pipeline_hazard_ctrl #(.REG_AW(REG_AW), .LAT_W(LAT_W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .hz      (hz)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Model state: cycles of MC_BUSY still owed, and the expected stall count
  int busy_left = 0;
  int sc_model  = 0;

  // {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, exmem_flush, mc_busy}
  logic [7:0] ctrl_obs;
  assign ctrl_obs = {hz.pc_we, hz.ifid_we, hz.ifid_flush, hz.idex_we, hz.idex_flush,
                     hz.exmem_we, hz.exmem_flush, hz.mc_busy};

  function automatic logic [7:0] exp_ctrl();
    bit lu;
    lu = hz.ex_mem_read && (hz.ex_rd != 0) &&
         ((hz.id_uses_rs && hz.id_rs == hz.ex_rd) || (hz.id_uses_rt && hz.id_rt == hz.ex_rd));
    if (!reset_n)                                        return 8'b0010_1010;
    if (busy_left > 0)                                   return 8'b0000_0111;
    if (hz.ex_branch_taken)                              return 8'b1111_1100;
    if (hz.ex_mc_start && int'(hz.ex_mc_latency) >= 2)   return 8'b0000_0110;
    if (lu)                                              return 8'b0001_1100;
    return 8'b1101_0100;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_in(input int rs, input int rt, input bit urs, input bit urt, input int rd,
                        input bit mr, input bit br, input bit st, input int lat);
    hz.id_rs           = REG_AW'(rs);
    hz.id_rt           = REG_AW'(rt);
    hz.id_uses_rs      = urs;
    hz.id_uses_rt      = urt;
    hz.ex_rd           = REG_AW'(rd);
    hz.ex_mem_read     = mr;
    hz.ex_branch_taken = br;
    hz.ex_mc_start     = st;
    hz.ex_mc_latency   = LAT_W'(lat);
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Called just after a negedge with inputs applied; optionally checks, then advances one clock
  task automatic cycle(input string tag, input bit chk);
    logic [7:0] e;
    #1;
    e = exp_ctrl();
    if (chk) begin
      check({tag, "/ctrl"}, 32'(ctrl_obs), 32'(e));
      check({tag, "/cnt"}, 32'(hz.stall_count), 32'(sc_model));
    end
    if (!reset_n) begin
      busy_left = 0;
      sc_model  = 0;
    end else begin
      if (!e[7] && sc_model < CNT_MAX) sc_model++;
      if (busy_left > 0) busy_left--;
      else if (!hz.ex_branch_taken && hz.ex_mc_start && int'(hz.ex_mc_latency) >= 2)
        busy_left = int'(hz.ex_mc_latency) - 1;
    end
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    @(negedge clk);
    cycle("reset0", 1);
    cycle("reset1", 1);
    reset_n = 1'b1;

    // Load-use on rs: one bubble, then clear
    set_in(5, 0, 1, 0, 5, 1, 0, 0, 0); cycle("lu_rs", 1);
    idle();                            cycle("lu_after", 1);
    // Load-use on rt
    set_in(1, 7, 0, 1, 7, 1, 0, 0, 0); cycle("lu_rt", 1);
    // Register match but operand not used: no hazard
    set_in(7, 7, 0, 0, 7, 1, 0, 0, 0); cycle("lu_unused", 1);
    // Load into r0 never stalls
    set_in(0, 0, 1, 1, 0, 1, 0, 0, 0); cycle("lu_r0", 1);
    // Taken branch masks load-use
    set_in(3, 0, 1, 0, 3, 1, 1, 0, 0); cycle("br_lu", 1);
    // Branch beats mc start
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 6); cycle("br_mc", 1);
    idle();                            cycle("br_mc_after", 1);
    // Latency 1 is a normal single-cycle op
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1); cycle("mc_lat1", 1);
    // Latency 4: start cycle plus three MC_BUSY cycles; inputs ignored while busy
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 4); cycle("mc4_start", 1);
    set_in(2, 0, 1, 0, 2, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle("mc4_busy", 1);
    idle();
    cycle("mc4_done", 1);
    cycle("mc4_idle", 1);

    // Reset in the middle of MC_BUSY
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 5); cycle("mc5_start", 1);
    idle();
    cycle("mc5_busy0", 1);
    cycle("mc5_busy1", 1);
    reset_n = 1'b0;                    cycle("mc5_reset", 1);
    reset_n = 1'b1;                    cycle("mc5_post", 1);
    cycle("mc5_post2", 1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset_n = ($urandom_range(0, 49) != 0);
      set_in($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
             $urandom_range(0, 3), ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 1),
             ($urandom_range(0, 9) < 1), $urandom_range(0, 15));
      cycle("rand", 1);
    end

    // Saturation: hold a load-use hazard for 65540 stall cycles
    reset_n = 1'b0; idle(); cycle("sat_reset", 1);
    reset_n = 1'b1;
    set_in(9, 0, 1, 0, 9, 1, 0, 0, 0);
    for (int i = 0; i < 65540; i++) cycle("sat_fill", (i < 3) || (i >= 65532));
    cycle("sat_hold", 1);
    idle();
    cycle("sat_idle", 1);
    check("sat_value", 32'(hz.stall_count), 32'h0000_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
